// File: rtl/fpu_pkg.sv
// Shared definitions for the binary32 arithmetic unit: opcodes, field widths,
// special encodings and helpers to unpack operands and pack truncated results.
package fpu_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int BIAS   = 127;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;

    // Exponent 0 covers both zero and denormals; both carry a zero mantissa.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign = x[31];
        u.exp  = x[30:23];
        u.mant = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        return u;
    endfunction

    function automatic logic [31:0] fp_pack(input logic sign,
                                            input logic signed [10:0] exp,
                                            input logic [FRAC_W-1:0] frac);
        if (exp >= 11'sd255)
            return {sign, 8'hFF, 23'd0};
        else if (exp < 11'sd1)
            return {sign, 31'd0};
        else
            return {sign, exp[7:0], frac};
    endfunction

endpackage

// File: rtl/fpu_addsub.sv
// Combinational binary32 add/subtract for finite operands: align, add or
// subtract magnitudes, normalise and truncate.
module fpu_addsub
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);

    fp_unpacked_t      ua, ub, ux, uy;
    logic              swap;
    logic [7:0]        diff;
    logic [47:0]       ax, ay;
    logic [48:0]       sum;
    logic [5:0]        lz;
    logic signed [10:0] exp_res;
    logic [22:0]       frac;

    // 24 extra low bits keep every shifted-out bit for alignments up to 24,
    // so truncation happens only once, after normalisation.
    always_comb begin
        ua = fp_unpack(a);
        ub = fp_unpack(b);
        ub.sign = b[31] ^ sub;
        swap = (ub.exp > ua.exp) || ((ub.exp == ua.exp) && (ub.mant > ua.mant));
        ux = swap ? ub : ua;
        uy = swap ? ua : ub;
        diff = ux.exp - uy.exp;
        ax = {ux.mant, 24'd0};
        ay = (diff >= 8'd25) ? 48'd0 : ({uy.mant, 24'd0} >> diff);
        sum = (ux.sign == uy.sign) ? ({1'b0, ax} + {1'b0, ay})
                                   : ({1'b0, ax} - {1'b0, ay});
        lz = 6'd0;
        for (int i = 0; i < 48; i++)
            if (sum[i]) lz = 6'(47 - i);
        if (sum[48]) begin
            exp_res = {3'b000, ux.exp} + 11'sd1;
            frac    = sum[47:25];
        end else begin
            exp_res = {3'b000, ux.exp} - {5'b00000, lz};
            frac    = 23'((sum[47:0] << lz) >> 24);
        end
        if (sum == 49'd0)
            result = {ua.sign & ub.sign, 31'd0};
        else
            result = fp_pack(ux.sign, exp_res, frac);
    end

endmodule

// File: rtl/fpu.sv
// Single-precision add/sub/div/mul execution stage: combinational datapath
// with special-value handling, result registered on every clock edge.
module fpu
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  opcode,
    output logic [31:0] outp
);

    fp_unpacked_t       ua, ub;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               prod_sign, eff_sign_b;
    logic [31:0]        addsub_res, mul_res, div_res, result_d;
    logic [47:0]        prod;
    logic signed [10:0] mul_exp, div_exp;
    logic [24:0]        div_q;
    logic [25:0]        div_rem;

    assign ua = fp_unpack(A);
    assign ub = fp_unpack(B);

    assign a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    assign b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    assign a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    assign b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    assign a_zero = (A[30:23] == 8'd0);
    assign b_zero = (B[30:23] == 8'd0);

    assign prod_sign  = ua.sign ^ ub.sign;
    assign eff_sign_b = ub.sign ^ (opcode == OP_SUB);

    fpu_addsub u_addsub (
        .a      (A),
        .b      (B),
        .sub    (opcode == OP_SUB),
        .result (addsub_res)
    );

    always_comb begin
        prod    = ua.mant * ub.mant;
        mul_exp = {3'b000, ua.exp} + {3'b000, ub.exp} - 11'sd127 + {10'd0, prod[47]};
        mul_res = fp_pack(prod_sign, mul_exp, 23'(prod >> (prod[47] ? 24 : 23)));
    end

    // Restoring division yields floor(mA * 2^24 / mB), which lies in [2^23, 2^25).
    always_comb begin
        div_q   = 25'd0;
        div_rem = {2'b00, ua.mant};
        for (int i = 24; i >= 0; i--) begin
            if (div_rem >= {2'b00, ub.mant}) begin
                div_q[i] = 1'b1;
                div_rem  = div_rem - {2'b00, ub.mant};
            end
            div_rem = div_rem << 1;
        end
        div_exp = {3'b000, ua.exp} - {3'b000, ub.exp} + 11'sd126 + {10'd0, div_q[24]};
        div_res = fp_pack(prod_sign, div_exp, 23'(div_q >> div_q[24]));
    end

    always_comb begin
        result_d = 32'd0;
        if (a_nan || b_nan) begin
            result_d = QNAN;
        end else begin
            case (opcode)
                OP_ADD, OP_SUB: begin
                    if (a_inf && b_inf)
                        result_d = (ua.sign == eff_sign_b) ? {ua.sign, POS_INF[30:0]} : QNAN;
                    else if (a_inf)
                        result_d = {ua.sign, POS_INF[30:0]};
                    else if (b_inf)
                        result_d = {eff_sign_b, POS_INF[30:0]};
                    else
                        result_d = addsub_res;
                end
                OP_MUL: begin
                    if ((a_inf && b_zero) || (a_zero && b_inf))
                        result_d = QNAN;
                    else if (a_inf || b_inf)
                        result_d = {prod_sign, POS_INF[30:0]};
                    else if (a_zero || b_zero)
                        result_d = {prod_sign, 31'd0};
                    else
                        result_d = mul_res;
                end
                default: begin
                    if ((a_zero && b_zero) || (a_inf && b_inf))
                        result_d = QNAN;
                    else if (a_inf || b_zero)
                        result_d = {prod_sign, POS_INF[30:0]};
                    else if (b_inf || a_zero)
                        result_d = {prod_sign, 31'd0};
                    else
                        result_d = div_res;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outp <= 32'd0;
        else
            outp <= result_d;
    end

endmodule

// File: tb/tb_fpu.sv
// Bench for fpu: directed cases from known binary32 values plus random
// operands checked against an integer-arithmetic reference model.
module tb_fpu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A, B;
    logic [1:0]  opcode;
    logic [31:0] outp;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    fpu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .opcode (opcode),
        .outp   (outp)
    );

    always #5 clk = ~clk;

    // Value m * 2^e, truncated toward zero into binary32 with flush/overflow.
    function automatic logic [31:0] pack_rz(input logic s, input longint unsigned m, input int e);
        int p;
        int be;
        longint unsigned mant;
        if (m == 0) return {s, 31'd0};
        p = 0;
        for (int i = 0; i < 64; i++)
            if (m[i]) p = i;
        mant = (p >= 23) ? (m >> (p - 23)) : (m << (23 - p));
        be = p + e + 127;
        if (be >= 255) return {s, 8'hFF, 23'd0};
        if (be <= 0) return {s, 31'd0};
        return {s, be[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] ref_fpu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic sa, sb, sx, sy;
        int ea, eb, ex, d;
        longint unsigned ma, mb, mx, my, bx, sm, s;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        ma = a_zero ? 64'd0 : ((64'd1 << 23) | 64'(a[22:0]));
        mb = b_zero ? 64'd0 : ((64'd1 << 23) | 64'(b[22:0]));
        if (a_nan || b_nan) return 32'h7FC00000;
        case (op)
            2'b00, 2'b01: begin
                if (op == 2'b01) sb = ~sb;
                if (a_inf && b_inf) return (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
                if (a_inf) return {sa, 8'hFF, 23'd0};
                if (b_inf) return {sb, 8'hFF, 23'd0};
                if (ea > eb || (ea == eb && ma >= mb)) begin
                    ex = ea; mx = ma; sx = sa; my = mb; sy = sb; d = ea - eb;
                end else begin
                    ex = eb; mx = mb; sx = sb; my = ma; sy = sa; d = eb - ea;
                end
                bx = mx << 24;
                sm = (d >= 25) ? 64'd0 : ((my << 24) >> d);
                s  = (sx == sy) ? bx + sm : bx - sm;
                if (s == 0) return {sa & sb, 31'd0};
                return pack_rz(sx, s, ex - 174);
            end
            2'b11: begin
                if ((a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC00000;
                if (a_inf || b_inf) return {sa ^ sb, 8'hFF, 23'd0};
                if (a_zero || b_zero) return {sa ^ sb, 31'd0};
                return pack_rz(sa ^ sb, ma * mb, ea + eb - 300);
            end
            default: begin
                if ((a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
                if (a_inf || b_zero) return {sa ^ sb, 8'hFF, 23'd0};
                if (b_inf || a_zero) return {sa ^ sb, 31'd0};
                return pack_rz(sa ^ sb, (ma << 24) / mb, ea - eb - 24);
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        @(negedge clk);
        A = a;
        B = b;
        opcode = op;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (outp !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_initial: got %h expected 00000000", outp);
        end
        @(negedge clk) rst_n = 1'b1;
        applyStimulus(32'h40000000, 32'h40400000, 2'b11);
        @(posedge clk); #1;
        tests_run++;
        if (outp !== 32'h40C00000) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_mul: got %h expected 40C00000", outp);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (outp !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got %h expected 00000000", outp);
        end
        @(posedge clk); #1;
        tests_run++;
        if (outp !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_hold: got %h expected 00000000", outp);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        tests_run++;
        if (outp !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_pre_edge: got %h expected 00000000", outp);
        end
        @(posedge clk); #1;
        tests_run++;
        if (outp !== 32'h40C00000) begin
            tests_failed++;
            $display("[TB] FAIL reset_first_edge: got %h expected 40C00000", outp);
        end
    endtask

    task automatic test_table(input string name, input vec_t v[]);
        foreach (v[i]) begin
            applyStimulus(v[i].a, v[i].b, v[i].op);
            @(posedge clk); #1;
            tests_run++;
            if (outp !== v[i].exp) begin
                tests_failed++;
                $display("[TB] FAIL %s[%0d] %h op%b %h: got %h expected %h",
                         name, i, v[i].a, v[i].op, v[i].b, outp, v[i].exp);
            end
        end
    endtask

    task automatic test_basic();
        vec_t v[];
        v = '{'{32'h40000000, 32'h40400000, 2'b11, 32'h40C00000},
              '{32'h40000000, 32'h40400000, 2'b00, 32'h40A00000},
              '{32'h40000000, 32'h40400000, 2'b01, 32'hBF800000},
              '{32'h40400000, 32'h40000000, 2'b10, 32'h3FC00000}};
        test_table("basic", v);
    endtask

    task automatic test_boundary();
        vec_t v[];
        v = '{'{32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000},
              '{32'h3F800000, 32'h3F800000, 2'b01, 32'h00000000},
              '{32'h7F000000, 32'h40000000, 2'b11, 32'h7F800000},
              '{32'h00800000, 32'h00800000, 2'b11, 32'h00000000},
              '{32'h80000000, 32'h80000000, 2'b00, 32'h80000000},
              '{32'h80000000, 32'h00000000, 2'b01, 32'h80000000},
              '{32'h00000001, 32'h00000000, 2'b00, 32'h00000000}};
        test_table("boundary", v);
    endtask

    task automatic test_specials();
        vec_t v[];
        v = '{'{32'h3F800000, 32'h00000000, 2'b10, 32'h7F800000},
              '{32'h00000000, 32'h00000000, 2'b10, 32'h7FC00000},
              '{32'h7F800000, 32'h7F800000, 2'b01, 32'h7FC00000},
              '{32'h7FC00000, 32'h3F800000, 2'b00, 32'h7FC00000},
              '{32'hBF800000, 32'h00000000, 2'b11, 32'h80000000},
              '{32'h7F800000, 32'h00000000, 2'b11, 32'h7FC00000},
              '{32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000},
              '{32'h7F800000, 32'hFF800000, 2'b01, 32'h7F800000},
              '{32'hBF800000, 32'h7F800000, 2'b10, 32'h80000000},
              '{32'h7F800000, 32'h7F800000, 2'b10, 32'h7FC00000}};
        test_table("specials", v);
    endtask

    task automatic test_back_to_back();
        vec_t v[];
        v = '{'{32'h40000000, 32'h40400000, 2'b00, 32'h40A00000},
              '{32'h40000000, 32'h40400000, 2'b11, 32'h40C00000},
              '{32'h40000000, 32'h40400000, 2'b10, 32'h3F2AAAAA},
              '{32'h40000000, 32'h40400000, 2'b01, 32'hBF800000}};
        foreach (v[i]) begin
            applyStimulus(v[i].a, v[i].b, v[i].op);
            #1;
            if (i > 0) begin
                tests_run++;
                if (outp !== v[i-1].exp) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_hold[%0d]: got %h expected %h", i, outp, v[i-1].exp);
                end
            end
            @(posedge clk); #1;
            tests_run++;
            if (outp !== v[i].exp) begin
                tests_failed++;
                $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, outp, v[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, expected;
        logic [1:0]  op;
        logic [7:0]  e;
        int          mode;
        for (int n = 0; n < 600; n++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            op = 2'($urandom_range(0, 3));
            if (mode == 1) begin
                e = 8'(int'(a[30:23]) + int'($urandom_range(0, 6)) - 3);
                b[30:23] = e;
            end else if (mode == 2) begin
                b = a ^ {1'b0, 31'($urandom_range(0, 255))};
                b[31] = $urandom_range(0, 1) == 1;
            end else if (mode == 3) begin
                a[30:23] = 8'($urandom_range(100, 155));
                b[30:23] = 8'($urandom_range(100, 155));
            end
            expected = ref_fpu(a, b, op);
            applyStimulus(a, b, op);
            @(posedge clk); #1;
            tests_run++;
            if (outp !== expected) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] %h op%b %h: got %h expected %h",
                         n, a, op, b, outp, expected);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        A = 32'h0;
        B = 32'h0;
        opcode = 2'b00;
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_boundary();
        test_specials();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
